// File: rtl/pipe_elastic_reg_if.sv
// pipe_elastic_reg_if: handshake bundle for pipe_elastic_reg.
//
// Groups the upstream (i_*), downstream (o_*) and control (redirect, flush)
// signals of one elastic pipeline register.
//   master : the side that drives i_valid/i_data, o_ready and the controls
//            and observes i_ready, o_valid, o_data, o_count.
//   slave  : the register itself.
// Parameters must match the pipe_elastic_reg instance they connect to.

interface pipe_elastic_reg_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_data;
    logic              flush;
    logic [CNT_W-1:0]  o_count;

    modport master (
        output i_valid, i_data, o_ready, redirect_valid, redirect_data, flush,
        input  i_ready, o_valid, o_data, o_count
    );

    modport slave (
        input  i_valid, i_data, o_ready, redirect_valid, redirect_data, flush,
        output i_ready, o_valid, o_data, o_count
    );
endinterface

// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: elastic pipeline register with redirect/flush.
//
// Holds up to DEPTH words: the output register (o_data) plus a circular skid
// FIFO of DEPTH-1 entries. i_ready, o_valid and o_count are registered and
// computed from the next occupancy, so o_ready never reaches i_ready
// combinationally. Redirect replaces all contents with one word (fetch-PC
// restart); flush empties the block.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   bus (slave modport)   i_valid/i_ready/i_data upstream handshake,
//                         o_valid/o_ready/o_data downstream handshake,
//                         redirect_valid/redirect_data, flush, o_count
//   o_stall_cnt           (PIPE_ELASTIC_STATS_EN only) cycles with
//                         i_valid & !i_ready, saturating
//   o_bubble_cnt          (PIPE_ELASTIC_STATS_EN only) cycles with
//                         !o_valid & o_ready, saturating
//
// Optional feature macro: PIPE_ELASTIC_STATS_EN.

module pipe_elastic_reg #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 2,
    parameter logic [31:0] RESET_VAL   = 32'h8000_0000,
    parameter bit          RESET_VALID = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    pipe_elastic_reg_if.slave bus
`ifdef PIPE_ELASTIC_STATS_EN
    ,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_bubble_cnt
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SKID  = DEPTH - 1;

    // Occupancy classes; count itself is the authoritative state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_PART  = 2'd2;
    localparam logic [1:0] ST_FULL  = 2'd3;

    logic [CNT_W-1:0]  count_q, count_next;
    logic              valid_q, ready_q;
    logic [DATA_W-1:0] data_q, data_next;
    logic [1:0]        state;
    logic              overflow;
    logic              insert, remove;
    logic              skid_push, skid_pop, skid_clr;
    logic [DATA_W-1:0] skid_head;

    assign insert = bus.i_valid & ready_q;
    assign remove = valid_q & bus.o_ready;

    // ------------------------------------------------------------------
    // State decode. Counts above DEPTH cannot occur in normal operation;
    // they are treated as EMPTY and the skid pointers are resynchronised.
    // ------------------------------------------------------------------
    always_comb begin
        overflow = (count_q > CNT_W'(DEPTH));
        if (count_q == '0 || overflow)
            state = ST_EMPTY;
        else if (count_q == CNT_W'(1))
            state = ST_BUSY;
        else if (count_q == CNT_W'(DEPTH))
            state = ST_FULL;
        else
            state = ST_PART;
    end

    // ------------------------------------------------------------------
    // Next occupancy and datapath steering.
    // ------------------------------------------------------------------
    always_comb begin
        count_next = count_q;
        data_next  = data_q;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        skid_clr   = 1'b0;

        if (bus.redirect_valid) begin
            // Any same-cycle remove has already consumed the old o_data;
            // a same-cycle insert is accepted and dropped.
            skid_clr   = 1'b1;
            data_next  = bus.redirect_data;
            count_next = CNT_W'(1);
        end else if (bus.flush) begin
            skid_clr   = 1'b1;
            count_next = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    skid_clr = overflow;
                    if (insert) begin
                        data_next  = bus.i_data;
                        count_next = CNT_W'(1);
                    end else begin
                        count_next = '0;
                    end
                end
                ST_BUSY: begin
                    if (insert && remove) begin
                        // Flow-through: the new word replaces the consumed one.
                        data_next = bus.i_data;
                    end else if (insert) begin
                        skid_push  = 1'b1;
                        count_next = CNT_W'(2);
                    end else if (remove) begin
                        // o_data left as is; o_valid drops.
                        count_next = '0;
                    end
                end
                default: begin
                    // ST_PART / ST_FULL: the skid holds count-1 words.
                    if (remove) begin
                        data_next = skid_head;
                        skid_pop  = 1'b1;
                    end
                    skid_push  = insert;
                    count_next = count_q + CNT_W'(insert) - CNT_W'(remove);
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register and registered handshake flags.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= CNT_W'(RESET_VALID);
            valid_q <= RESET_VALID;
            ready_q <= 1'b1;
            data_q  <= DATA_W'(RESET_VAL);
        end else begin
            count_q <= count_next;
            valid_q <= (count_next != '0);
            // Space is guaranteed for one insert on the following cycle.
            ready_q <= (count_next < CNT_W'(DEPTH));
            data_q  <= data_next;
        end
    end

    assign bus.i_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_count = count_q;

    // ------------------------------------------------------------------
    // Skid FIFO. Contents are only meaningful up to count-1 entries, so the
    // storage itself is never cleared; only the pointers are.
    // ------------------------------------------------------------------
    generate
        if (SKID == 1) begin : g_skid_reg
            logic [DATA_W-1:0] skid_q;
            // Single entry: push and pop always target the same register.
            logic unused_skid_ctl;
            assign unused_skid_ctl = skid_pop ^ skid_clr;

            always_ff @(posedge clk) begin
                if (skid_push)
                    skid_q <= bus.i_data;
            end

            assign skid_head = skid_q;
        end else begin : g_skid_ring
            localparam int PTR_W = $clog2(SKID);

            logic [DATA_W-1:0] mem [SKID];
            logic [PTR_W-1:0]  head_q, tail_q;

            // Wrap modulo SKID, which need not be a power of two.
            function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
                return (p == PTR_W'(SKID - 1)) ? '0 : p + 1'b1;
            endfunction

            always_ff @(posedge clk) begin
                if (!rst_n || skid_clr) begin
                    head_q <= '0;
                    tail_q <= '0;
                end else begin
                    if (skid_push)
                        tail_q <= wrap_inc(tail_q);
                    if (skid_pop)
                        head_q <= wrap_inc(head_q);
                end
            end

            always_ff @(posedge clk) begin
                if (skid_push)
                    mem[tail_q] <= bus.i_data;
            end

            assign skid_head = mem[head_q];
        end
    endgenerate

`ifdef PIPE_ELASTIC_STATS_EN
    // ------------------------------------------------------------------
    // Saturating stall/bubble counters; only reset clears them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_stall_cnt  <= '0;
            o_bubble_cnt <= '0;
        end else begin
            if (bus.i_valid && !ready_q && o_stall_cnt != '1)
                o_stall_cnt <= o_stall_cnt + 32'd1;
            if (!valid_q && bus.o_ready && o_bubble_cnt != '1)
                o_bubble_cnt <= o_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
